// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration master.
// Holds the FSM state encoding and the interrupt pulse length.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    TURNAROUND,
    CAPTURE,
    CS_HOLD,
    DONE
  } state_t;

  localparam int IRQ_LEN = 16;
  localparam int IRQ_CW  = $clog2(IRQ_LEN + 1);

  // Wide enough for any setup/hold/turnaround cycle count.
  localparam int CYC_W   = 16;

endpackage

// File: rtl/spi_cfg_master_if.sv
// Command/response/SPI pin bundle of the SPI configuration master.
// The master modport is the controller side; slave is the host/pad side.
interface spi_cfg_master_if
  import spi_cfg_pkg::*;
#(
  parameter int FRAME_W = 24,
  parameter int RD_W    = 8,
  parameter int NUM_CS  = 4
);
  localparam int CS_W = $clog2(NUM_CS) + 1;

  // cmd: a transfer is accepted in the cycle cmd_valid && cmd_ready are both
  // high; cmd_rw/cmd_cs/cmd_data are sampled in that same cycle. rsp_valid is
  // a one-cycle pulse with no back-pressure.
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_rw;
  logic [CS_W-1:0]      cmd_cs;
  logic [FRAME_W-1:0]   cmd_data;

  logic                 rsp_valid;
  logic                 rsp_rw;
  logic                 rsp_err;
  logic [RD_W-1:0]      rsp_data;

  logic                 spi_clk_o;
  logic [NUM_CS-1:0]    spi_cs_n_o;
  logic                 spi_sdata_o;
  logic                 spi_sdata_i;
  logic                 spi_io_select;
  logic                 busy;
  logic                 irq;
  state_t               dbg_state;

  modport master (
    input  cmd_valid, cmd_rw, cmd_cs, cmd_data, spi_sdata_i,
    output cmd_ready, rsp_valid, rsp_rw, rsp_err, rsp_data,
    output spi_clk_o, spi_cs_n_o, spi_sdata_o, spi_io_select, busy, irq, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_cs, cmd_data, spi_sdata_i,
    input  cmd_ready, rsp_valid, rsp_rw, rsp_err, rsp_data,
    input  spi_clk_o, spi_cs_n_o, spi_sdata_o, spi_io_select, busy, irq, dbg_state
  );

endinterface

// File: rtl/spi_cfg_clk_gen.sv
// SCLK generator: CLK_DIV sys_clk cycles per half period, low half first.
// Held in reset (SCLK low) whenever i_en is low.
module spi_cfg_clk_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_half_end;

  assign w_half_end = (r_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_half_end) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Rise marks the first high cycle; fall marks the last high cycle so the
  // next data bit appears together with SCLK going low.
  assign o_sclk = r_phase;
  assign o_rise = i_en && r_phase && (r_cnt == '0);
  assign o_fall = i_en && r_phase && w_half_end;

endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 configuration master with 3-wire read turnaround.
// Optional completion interrupt enabled by defining SPI_CFG_MASTER_IRQ_EN.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int FRAME_W      = 24,
  parameter int RD_W         = 8,
  parameter int NUM_CS       = 4,
  parameter int CLK_DIV      = 5,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  spi_cfg_master_if.master   bus
);
  localparam int CS_W    = $clog2(NUM_CS) + 1;
  localparam int SH_BITS = FRAME_W - RD_W;
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CYC_W-1:0]   r_cyc;
  logic [BIT_W-1:0]   r_bit;
  logic               r_rw;
  logic               r_err;
  logic [CS_W-1:0]    r_cs;
  logic [FRAME_W-1:0] r_shift;
  logic [RD_W-1:0]    r_rx;

  logic w_hs;
  logic w_bad_cs;
  logic w_sclk_en;
  logic w_sclk;
  logic w_rise;
  logic w_fall;
  logic w_last_sh;
  logic w_last_cap;
  logic w_cs_act;

  assign w_hs       = bus.cmd_valid && bus.cmd_ready;
  assign w_bad_cs   = (bus.cmd_cs >= CS_W'(NUM_CS));
  assign w_sclk_en  = (r_state == SHIFT) || (r_state == CAPTURE);
  assign w_last_sh  = w_fall && (r_bit == (r_rw ? BIT_W'(SH_BITS - 1) : BIT_W'(FRAME_W - 1)));
  assign w_last_cap = w_fall && (r_bit == BIT_W'(RD_W - 1));

  spi_cfg_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_en    (w_sclk_en),
    .o_sclk  (w_sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       if (w_hs) w_state_nxt = w_bad_cs ? DONE : CS_SETUP;
      CS_SETUP:   if (r_cyc == CYC_W'(CS_SETUP_CYC - 1)) w_state_nxt = SHIFT;
      SHIFT:      if (w_last_sh) w_state_nxt = r_rw ? TURNAROUND : CS_HOLD;
      TURNAROUND: if (r_cyc == CYC_W'(CLK_DIV - 1)) w_state_nxt = CAPTURE;
      CAPTURE:    if (w_last_cap) w_state_nxt = CS_HOLD;
      CS_HOLD:    if (r_cyc == CYC_W'(CS_HOLD_CYC - 1)) w_state_nxt = DONE;
      DONE:       w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Cycle and bit counters restart on every state change.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cyc <= '0;
        r_bit <= '0;
      end else begin
        r_cyc <= r_cyc + 1'b1;
        if (w_fall) r_bit <= r_bit + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rw    <= 1'b0;
      r_err   <= 1'b0;
      r_cs    <= '0;
      r_shift <= '0;
      r_rx    <= '0;
    end else if (w_hs) begin
      r_rw    <= bus.cmd_rw;
      r_err   <= w_bad_cs;
      r_cs    <= bus.cmd_cs;
      r_shift <= bus.cmd_data;
      r_rx    <= '0;
    end else begin
      if ((r_state == SHIFT) && w_fall) r_shift <= r_shift << 1;
      if ((r_state == CAPTURE) && w_rise) r_rx <= (r_rx << 1) | RD_W'(bus.spi_sdata_i);
    end
  end

  assign w_cs_act = (r_state != IDLE) && (r_state != DONE);

  always_comb begin
    bus.spi_cs_n_o = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (w_cs_act && (r_cs == CS_W'(i))) bus.spi_cs_n_o[i] = 1'b0;
    end
  end

  assign bus.cmd_ready     = (r_state == IDLE) && !sys_rst;
  assign bus.busy          = (r_state != IDLE);
  assign bus.dbg_state     = r_state;
  assign bus.spi_clk_o     = w_sclk;
  assign bus.spi_sdata_o   = ((r_state == CS_SETUP) || (r_state == SHIFT)) ? r_shift[FRAME_W-1] : 1'b0;
  // The pad stays turned around until chip select is about to be released.
  assign bus.spi_io_select = !((r_state == TURNAROUND) || (r_state == CAPTURE) ||
                               ((r_state == CS_HOLD) && r_rw));
  assign bus.rsp_valid     = (r_state == DONE);
  assign bus.rsp_rw        = (r_state == DONE) && r_rw;
  assign bus.rsp_err       = (r_state == DONE) && r_err;
  assign bus.rsp_data      = ((r_state == DONE) && r_rw && !r_err) ? r_rx : '0;

`ifdef SPI_CFG_MASTER_IRQ_EN
  logic [IRQ_CW-1:0] r_irq_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_irq_cnt <= '0;
    end else if ((r_state == DONE) && !bus.cmd_valid) begin
      r_irq_cnt <= IRQ_CW'(IRQ_LEN);
    end else if (r_irq_cnt != '0) begin
      r_irq_cnt <= r_irq_cnt - 1'b1;
    end
  end

  assign bus.irq = (r_irq_cnt != '0);
`else
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_master.sv
// Self-checking bench for spi_cfg_master: vector table, reset abort,
// back-to-back reads and the completion interrupt window.
module tb_spi_cfg_master;
  import spi_cfg_pkg::*;

  localparam int FRAME_W = 24;
  localparam int RD_W    = 8;
  localparam int NUM_CS  = 4;
  localparam int CS_W    = 3;
`ifdef SPI_CFG_MASTER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  logic [RD_W+1:0] exp_q[$];

  typedef struct {
    logic            rw;
    logic [CS_W-1:0] cs;
    logic [23:0]     data;
    logic [7:0]      slave;
    int              exp_lat;
    logic            exp_err;
    logic [7:0]      exp_rdata;
    int              exp_io_lat;
    int              exp_pulses;
    int              exp_nmosi;
    logic [23:0]     exp_mosi;
  } vec_t;

  vec_t vecs[8];

  spi_cfg_master_if #(.FRAME_W(FRAME_W), .RD_W(RD_W), .NUM_CS(NUM_CS)) bus ();

  spi_cfg_master #(
    .FRAME_W(FRAME_W), .RD_W(RD_W), .NUM_CS(NUM_CS),
    .CLK_DIV(5), .CS_SETUP_CYC(2), .CS_HOLD_CYC(2)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.master)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [CS_W-1:0] cs,
                              input logic [23:0] data, input logic [7:0] slave);
    vec_t v;
    logic err;
    err          = (cs >= CS_W'(NUM_CS));
    v.rw         = rw;
    v.cs         = cs;
    v.data       = data;
    v.slave      = slave;
    v.exp_err    = err;
    v.exp_lat    = err ? 1 : (rw ? 250 : 245);
    v.exp_rdata  = (rw && !err) ? slave : 8'h00;
    v.exp_io_lat = (rw && !err) ? 163 : 0;
    v.exp_pulses = err ? 0 : 24;
    v.exp_nmosi  = err ? 0 : (rw ? 16 : 24);
    v.exp_mosi   = err ? 24'h0 : (rw ? {8'h00, data[23:8]} : data);
    return v;
  endfunction

  task automatic check_reset_outputs(input string name);
    check(name,
          {8'h0, bus.cmd_ready, bus.spi_cs_n_o, bus.spi_clk_o, bus.spi_sdata_o, bus.spi_io_select,
           bus.rsp_valid, bus.rsp_err, bus.rsp_rw, bus.rsp_data, bus.busy, bus.irq, bus.dbg_state},
          {8'h0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, IDLE});
  endtask

  // driver: called at a negedge, returns at the negedge of cycle T+1
  task automatic send_cmd(input logic rw, input logic [CS_W-1:0] cs, input logic [23:0] data,
                          output bit ok);
    bus.cmd_rw    = rw;
    bus.cmd_cs    = cs;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      if (bus.cmd_ready) begin
        @(posedge sys_clk);
        ok = 1'b1;
      end
      @(negedge sys_clk);
    end
    if (!ok) check("handshake timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input bit keep_valid);
    logic [23:0] mosi = '0;
    logic [3:0]  exp_cs;
    int nmosi = 0, pulses = 0, io_lat = 0, rbit = 0, lat = 1, bad = 0;
    bit prev = 1'b0, ok;
    exp_q.push_back({v.exp_err, v.rw, v.exp_rdata});
    send_cmd(v.rw, v.cs, v.data, ok);
    if (!ok) begin
      void'(exp_q.pop_back());
      return;
    end
    if (!keep_valid) bus.cmd_valid = 1'b0;
    exp_cs = v.exp_err ? 4'hF : ~(4'b0001 << v.cs);
    while (!bus.rsp_valid && lat < 400) begin
      if (bus.spi_cs_n_o !== exp_cs || bus.busy !== 1'b1) bad++;
      if (bus.spi_clk_o && !prev) begin
        pulses++;
        if (bus.spi_io_select) begin
          mosi = {mosi[22:0], bus.spi_sdata_o};
          nmosi++;
        end
      end
      // slave model: present the next read bit after each SCLK fall
      if (!bus.spi_io_select) begin
        if (io_lat == 0) io_lat = lat;
        else if (!bus.spi_clk_o && prev) rbit++;
        bus.spi_sdata_i = (rbit < RD_W) ? v.slave[RD_W-1-rbit] : 1'b0;
      end
      prev = bus.spi_clk_o;
      @(negedge sys_clk);
      lat++;
    end
    bus.spi_sdata_i = 1'b0;
    check("rsp latency", lat, v.exp_lat);
    if (bus.rsp_valid)
      check("rsp fields", {bus.rsp_err, bus.rsp_rw, bus.rsp_data}, exp_q.pop_front());
    else begin
      void'(exp_q.pop_front());
      check("rsp missing", 32'd0, 32'd1);
    end
    check("cs_n/busy during frame", bad, 0);
    check("done cs_n high", bus.spi_cs_n_o, 4'hF);
    check("sclk pulses", pulses, v.exp_pulses);
    check("mosi bit count", nmosi, v.exp_nmosi);
    check("mosi value", mosi, v.exp_mosi);
    check("io_select turn cycle", io_lat, v.exp_io_lat);
  endtask

  // called at the DONE negedge with cmd_valid low
  task automatic check_irq();
    int bad = 0, bad_rv = 0;
    logic exp;
    for (int k = 0; k <= 17; k++) begin
      exp = IRQ_ON && (k >= 1) && (k <= 16);
      if (bus.irq !== exp) bad++;
      if (k >= 1 && bus.rsp_valid !== 1'b0) bad_rv++;
      if (k < 17) @(negedge sys_clk);
    end
    check("irq window", bad, 0);
    check("rsp_valid single cycle", bad_rv, 0);
  endtask

  initial begin
    vec_t a, b;
    bit ok;
    int pulses, seen_rv;
    bit prev;

    bus.cmd_valid   = 1'b0;
    bus.cmd_rw      = 1'b0;
    bus.cmd_cs      = '0;
    bus.cmd_data    = '0;
    bus.spi_sdata_i = 1'b0;
    sys_rst         = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset state");
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("cmd_ready after reset", bus.cmd_ready, 1'b1);

    vecs[0] = mk(1'b0, 3'd1, 24'h81_23_45, 8'h00);
    vecs[1] = mk(1'b1, 3'd0, 24'h80_10_00, 8'hA5);
    vecs[2] = mk(1'b0, 3'd4, 24'h12_34_56, 8'h00);
    vecs[3] = mk(1'b0, 3'd3, 24'($urandom_range(32'hFF_FFFF, 0)), 8'h00);
    vecs[4] = mk(1'b1, 3'd2, 24'($urandom_range(32'hFF_FFFF, 0)), 8'($urandom_range(255, 0)));
    vecs[5] = mk(1'b1, 3'd7, 24'hAB_CD_EF, 8'h5A);
    vecs[6] = mk(1'b0, 3'd0, 24'hFF_FF_FF, 8'h00);
    vecs[7] = mk(1'b1, 3'd3, 24'h00_00_00, 8'hFF);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], 1'b0);
      check_irq();
    end

    // reset in the middle of a write, at the 10th SCLK pulse
    send_cmd(1'b0, 3'd2, 24'hC3_5A_0F, ok);
    bus.cmd_valid = 1'b0;
    pulses = 0;
    prev   = 1'b0;
    for (int k = 0; k < 300 && pulses < 10; k++) begin
      if (bus.spi_clk_o && !prev) pulses++;
      prev = bus.spi_clk_o;
      if (pulses < 10) @(negedge sys_clk);
    end
    check("pulses before abort", pulses, 10);
    #2 sys_rst = 1'b1;
    #1 check_reset_outputs("mid-frame reset");
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    seen_rv = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      if (bus.rsp_valid) seen_rv++;
    end
    check("no rsp after abort", seen_rv, 0);
    check("idle cs_n after abort", bus.spi_cs_n_o, 4'hF);
    run_vec(vecs[0], 1'b0);
    check_irq();

    // back-to-back reads with cmd_valid held high
    a = mk(1'b1, 3'd1, 24'h80_10_00, 8'h3C);
    b = mk(1'b1, 3'd3, 24'h9A_BC_DE, 8'hC6);
    run_vec(a, 1'b1);
    @(negedge sys_clk);
    check("b2b idle gap", {bus.spi_cs_n_o, bus.cmd_ready, bus.busy}, {4'hF, 1'b1, 1'b0});
    run_vec(b, 1'b0);
    check_irq();

    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 SHALL have parameter FRAME_W, default 24, total serial frame length in bits (address+data).
REQ-002 SHALL have parameter RD_W, default 8, read-data bits captured after turnaround; legal range 1..FRAME_W-1.
REQ-003 SHALL have parameter NUM_CS, default 4, number of chip selects.
REQ-004 SHALL have parameter CLK_DIV, default 5, sys_clk cycles per SCLK half-period; minimum 2.
REQ-005 SHALL have parameters CS_SETUP_CYC, default 2, and CS_HOLD_CYC, default 2, both in sys_clk cycles; minimum 1.
REQ-006 SHALL have ports: sys_clk in 1 (sole clock, 100 MHz); sys_rst in 1 (asynchronous, active-high).
REQ-007 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_rw in 1 (0 write, 1 read); cmd_cs in $clog2(NUM_CS)+1 (target select); cmd_data in FRAME_W (MSB first).
REQ-008 SHALL have ports: rsp_valid out 1; rsp_rw out 1; rsp_err out 1; rsp_data out RD_W.
REQ-009 SHALL have ports: spi_clk_o out 1; spi_cs_n_o out NUM_CS; spi_sdata_o out 1; spi_sdata_i in 1; spi_io_select out 1 (1 FPGA drives SDIO, 0 input); busy out 1; irq out 1.

Function
REQ-010 SHALL use states IDLE, CS_SETUP, SHIFT, TURNAROUND, CAPTURE, CS_HOLD, DONE.
REQ-011 SHALL assert cmd_ready only in IDLE; handshake = cmd_valid&&cmd_ready in cycle T, latching cmd_rw/cmd_cs/cmd_data.
REQ-012 SHALL, if latched cmd_cs >= NUM_CS, go IDLE->DONE with no CS/SCLK activity, rsp_err=1, rsp_data=0.
REQ-013 SHALL, in CS_SETUP (T+1..T+CS_SETUP_CYC), drive selected spi_cs_n_o low, spi_sdata_o = frame MSB, spi_clk_o low.
REQ-014 SHALL use SPI mode 0: SCLK low first half-bit, high second half; sdata_o changes only at SCLK falling edge; sdata_i sampled in the sys_clk cycle of SCLK rising edge.
REQ-015 SHALL, for write, shift all FRAME_W bits in SHIFT (FRAME_W*2*CLK_DIV cycles), then CS_HOLD.
REQ-016 SHALL, for read, shift FRAME_W-RD_W bits, enter TURNAROUND for CLK_DIV cycles with SCLK low and spi_io_select=0, then CAPTURE RD_W bits MSB first; spi_io_select stays 0 until CS_HOLD ends.
REQ-017 SHALL hold SCLK low and cs_n low for CS_HOLD_CYC cycles in CS_HOLD, then deassert all cs_n in DONE.
REQ-018 SHALL pulse rsp_valid for exactly one cycle in DONE; rsp_data = captured bits for read, 0 for write; rsp_rw = latched cmd_rw; rsp_err=0 unless REQ-012.
REQ-019 SHALL return DONE->IDLE next cycle; busy = (state != IDLE).
REQ-020 SHALL ignore cmd_valid changes while busy; back-to-back commands separated by at least one IDLE cycle with all cs_n high.
REQ-021 SHALL drive at most one cs_n low at any time.

Reset
REQ-022 SHALL, on sys_rst high at any time including mid-frame, immediately force: state IDLE, cmd_ready 0 while reset asserted, spi_cs_n_o all 1, spi_clk_o 0, spi_sdata_o 0, spi_io_select 1, rsp_valid 0, rsp_err 0, rsp_rw 0, rsp_data 0, busy 0, irq 0.
REQ-023 SHALL NOT emit rsp_valid for a frame aborted by reset.

Configuration
REQ-024 SHALL, with SPI_CFG_MASTER_IRQ_EN defined, assert irq for 16 cycles starting the cycle after rsp_valid when cmd_valid is low in that DONE cycle; a new rsp_valid restarts the count.
REQ-025 SHALL, without SPI_CFG_MASTER_IRQ_EN, tie irq to 0 and contain no irq counter.

Structure
REQ-026 SHALL place the state enum and IRQ_LEN=16 in package spi_cfg_pkg.
REQ-027 SHALL instantiate sub-module spi_cfg_clk_gen (CLK_DIV counter producing sclk level plus rise/fall strobes, enabled only in SHIFT/CAPTURE).

Verification
REQ-028 Write, defaults, cmd_data=24'h81_23_45, cmd_cs=1 -> cs_n_o[1] low T+1..T+244, 24 SCLK pulses, MOSI 0x812345 MSB first, rsp_valid at T+245 with rsp_rw=0, rsp_data=0.
REQ-029 Read, cmd_data=24'h80_10_00, slave returns 8'hA5 -> io_select 0 from T+163, rsp_valid at T+250, rsp_data=8'hA5.
REQ-030 cmd_cs=4 (NUM_CS=4) -> no cs_n activity, rsp_valid at T+1 with rsp_err=1.
REQ-031 sys_rst pulsed at bit 10 of a write -> all cs_n high, SCLK 0 same cycle, no rsp_valid; next command completes normally.
REQ-032 IRQ_EN defined, single write with cmd_valid low after -> irq high exactly 16 cycles from T+246; undefined -> irq constant 0.
REQ-033 Back-to-back reads with cmd_valid held high -> one IDLE cycle with all cs_n high between frames, two rsp_valid pulses.
